// File: rtl/tts_pkg.sv
// rtl/tts_pkg.sv - shared TTS code constants and rate-monitor state encoding
package tts_pkg;

  localparam logic [3:0] TTS_READY    = 4'b1000;
  localparam logic [3:0] TTS_OVF_WARN = 4'b0001;
  localparam logic [3:0] TTS_BUSY     = 4'b0100;
  localparam logic [3:0] TTS_SYNC_LOST = 4'b0010;
  localparam logic [3:0] TTS_ERROR    = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_ERROR   = 2'd2
  } mon_state_t;

endpackage

// File: rtl/window_timer.sv
// rtl/window_timer.sv - free-running 0..WINDOW_CYCLES-1 counter with sync restart and window-end strobe
module window_timer #(
  parameter int WINDOW_CYCLES = 125000,
  parameter int TW = $clog2(WINDOW_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic window_end
);

  localparam logic [TW-1:0] LAST = TW'(WINDOW_CYCLES - 1);

  logic [TW-1:0] count;

  assign window_end = run && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || restart || window_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/trig_rate_monitor.sv
// rtl/trig_rate_monitor.sv - windowed trigger-rate check feeding error_trig_rate; TRIG_RATE_PEAK_EN adds peak_count
module trig_rate_monitor
  import tts_pkg::*;
#(
  parameter int WINDOW_CYCLES   = 125000,
  parameter int CNT_W           = 16,
  parameter int RECOVER_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             trigger,
  input  logic [CNT_W-1:0] threshold,
  input  logic             clear_error,
  output logic             error_trig_rate,
  output logic             window_done,
  output logic [CNT_W-1:0] window_count
`ifdef TRIG_RATE_PEAK_EN
  ,
  output logic [CNT_W-1:0] peak_count
`endif
);

  localparam int REC_W = $clog2(RECOVER_WINDOWS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_WINDOWS - 1);

  mon_state_t       state;
  logic [CNT_W-1:0] trig_cnt;
  logic [REC_W-1:0] rec_cnt;
  logic [CNT_W-1:0] closing;
  logic             over;
  logic             run;
  logic             win_end;

  assign run = (state != ST_IDLE);

  window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_window_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .restart   (clear_error || !enable),
    .window_end(win_end)
  );

  // Total including this cycle's trigger, so a window-end trigger belongs to the closing window.
  assign closing = (trigger && (trig_cnt != CNT_MAX)) ? trig_cnt + 1'b1 : trig_cnt;
  assign over    = (threshold != '0) && (closing > threshold);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      trig_cnt        <= '0;
      rec_cnt         <= '0;
      error_trig_rate <= 1'b0;
      window_done     <= 1'b0;
      window_count    <= '0;
`ifdef TRIG_RATE_PEAK_EN
      peak_count      <= '0;
`endif
    end else begin
      window_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          trig_cnt        <= '0;
          rec_cnt         <= '0;
          error_trig_rate <= 1'b0;
          if (enable) state <= ST_MONITOR;
        end
        ST_MONITOR, ST_ERROR: begin
          if (!enable) begin
            state           <= ST_IDLE;
            trig_cnt        <= '0;
            rec_cnt         <= '0;
            error_trig_rate <= 1'b0;
          end else if (clear_error) begin
            state           <= ST_MONITOR;
            trig_cnt        <= '0;
            rec_cnt         <= '0;
            error_trig_rate <= 1'b0;
`ifdef TRIG_RATE_PEAK_EN
            peak_count      <= '0;
`endif
          end else if (win_end) begin
            trig_cnt     <= '0;
            window_count <= closing;
            window_done  <= 1'b1;
`ifdef TRIG_RATE_PEAK_EN
            if (closing > peak_count) peak_count <= closing;
`endif
            if (state == ST_MONITOR) begin
              rec_cnt <= '0;
              if (over) begin
                state           <= ST_ERROR;
                error_trig_rate <= 1'b1;
              end
            end else if (over) begin
              rec_cnt <= '0;
            end else if (rec_cnt == REC_LAST) begin
              state           <= ST_MONITOR;
              error_trig_rate <= 1'b0;
              rec_cnt         <= '0;
            end else begin
              rec_cnt <= rec_cnt + 1'b1;
            end
          end else begin
            trig_cnt <= closing;
          end
        end
        default: begin
          state           <= ST_IDLE;
          error_trig_rate <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_rate_monitor.sv
// tb/tb_trig_rate_monitor.sv - randomized window-level checks of trig_rate_monitor against a per-window model
module tb_trig_rate_monitor;

  localparam int WC = 100;
  localparam int CW = 4;
  localparam int RW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          trigger = 1'b0;
  logic          clear_error = 1'b0;
  logic [CW-1:0] threshold = 4'd5;
  logic          error_trig_rate;
  logic          window_done;
  logic [CW-1:0] window_count;
`ifdef TRIG_RATE_PEAK_EN
  logic [CW-1:0] peak_count;
`endif

  int total = 0;
  int bad = 0;

  int m_err = 0;
  int m_rec = 0;
  int m_cnt = 0;
  int m_peak = 0;
  bit pending = 0;

  trig_rate_monitor #(
    .WINDOW_CYCLES  (WC),
    .CNT_W          (CW),
    .RECOVER_WINDOWS(RW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .trigger        (trigger),
    .threshold      (threshold),
    .clear_error    (clear_error),
    .error_trig_rate(error_trig_rate),
    .window_done    (window_done),
    .window_count   (window_count)
`ifdef TRIG_RATE_PEAK_EN
    ,
    .peak_count     (peak_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_boundary(input string tag);
    chk({tag, "_done"}, 32'(window_done), 32'(pending));
    chk({tag, "_count"}, 32'(window_count), 32'(m_cnt));
    chk({tag, "_err"}, 32'(error_trig_rate), 32'(m_err));
`ifdef TRIG_RATE_PEAK_EN
    chk({tag, "_peak"}, 32'(peak_count), 32'(m_peak));
`endif
  endtask

  // Per-window rule: saturated total, strict compare, recovery after RW quiet windows.
  task automatic close_window(input int ones, input int thr);
    int tot;
    bit ov;
    tot = (ones > CMAX) ? CMAX : ones;
    ov = (thr != 0) && (tot > thr);
    if (m_err == 0) begin
      m_rec = 0;
      if (ov) m_err = 1;
    end else if (ov) begin
      m_rec = 0;
    end else begin
      m_rec++;
      if (m_rec == RW) begin
        m_err = 0;
        m_rec = 0;
      end
    end
    m_cnt = tot;
    if (tot > m_peak) m_peak = tot;
    pending = 1;
  endtask

  task automatic run_window(input string tag, input int n, input bit last_end, input bit hold,
                            input bit clr_end, input int thr);
    bit pat[WC];
    int placed;
    int r;
    int ones;
    placed = 0;
    ones = 0;
    for (int i = 0; i < WC; i++) pat[i] = hold;
    if (!hold && last_end && n > 0) begin
      pat[WC-1] = 1'b1;
      placed = 1;
    end
    while (!hold && placed < n) begin
      r = int'($urandom_range(0, last_end ? WC - 2 : WC - 1));
      if (!pat[r]) begin
        pat[r] = 1'b1;
        placed++;
      end
    end
    for (int p = 0; p < WC; p++) begin
      @(negedge clk);
      if (p == 0) begin
        check_boundary(tag);
        pending = 0;
        threshold = CW'(thr);
      end else begin
        chk({tag, "_nodone"}, 32'(window_done), 32'd0);
      end
      if (p == WC / 2) chk({tag, "_miderr"}, 32'(error_trig_rate), 32'(m_err));
      trigger = pat[p];
      clear_error = clr_end && (p == WC - 1);
      if (pat[p]) ones++;
    end
    if (clr_end) begin
      m_err = 0;
      m_rec = 0;
      m_peak = 0;
      pending = 0;
    end else begin
      close_window(ones, thr);
    end
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    check_boundary(tag);
    pending = 0;
    trigger = 1'b0;
    clear_error = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_boundary("reset");
    reset = 1'b1;
    @(negedge clk);
    check_boundary("idle");
    enable = 1'b1;

    run_window("t1a", 5, 0, 0, 0, 5);
    run_window("t1b", 5, 0, 0, 0, 5);
    run_window("t1c", 5, 0, 0, 0, 5);
    run_window("t1r", int'($urandom_range(0, 5)), 0, 0, 0, 5);

    run_window("t2", 6, 1, 0, 0, 5);

    run_window("t3a", 3, 0, 0, 0, 5);
    run_window("t3b", 9, 0, 0, 0, 5);
    run_window("t3c", 2, 0, 0, 0, 5);
    run_window("t3d", 0, 0, 0, 0, 5);

    run_window("t4", 0, 0, 1, 0, 0);

    run_window("t5a", 8, 0, 0, 0, 5);
    run_window("t5clr", int'($urandom_range(0, 10)), 0, 0, 1, 5);
    run_window("t5b", 2, 0, 0, 0, 5);

    run_window("t6a", 3, 0, 0, 0, 5);
    run_window("t6b", 7, 0, 0, 0, 5);
    run_window("t6c", 4, 0, 0, 0, 5);
    settle("t6end");
    repeat (40) begin
      @(negedge clk);
      trigger = 1'($urandom_range(0, 1));
    end
    chk("pre_reset_err", 32'(error_trig_rate), 32'd1);
    #2 reset = 1'b0;
    #1;
    m_err = 0;
    m_rec = 0;
    m_cnt = 0;
    m_peak = 0;
    pending = 0;
    check_boundary("async_reset");
    trigger = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    run_window("t7a", 9, 0, 0, 0, 5);
    settle("t7end");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    m_err = 0;
    check_boundary("disable");
    repeat (WC + 5) @(negedge clk);
    check_boundary("idle_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trig_rate_monitor.md
Name: trig_rate_monitor

Overview:
- Upstream feeder of the TTS reporter: generates the `error_trig_rate` input that the reporter ORs into its Error state.
- Counts accepted triggers over fixed, back-to-back clock windows and compares each window total against a programmable threshold.
- Once the threshold is exceeded, it holds the error and releases it only after a configurable run of consecutive quiet windows, or on an explicit clear.

Parameters:
- WINDOW_CYCLES, 125000, clocks per measurement window (1 ms at 125 MHz); must be >= 2.
- CNT_W, 16, width of the trigger counter, threshold and reported count.
- RECOVER_WINDOWS, 4, consecutive windows with count <= threshold required to leave ERROR; must be >= 1.

Ports:
- clk  input  1  user interface clock.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- enable  input  1  monitoring enable; low forces IDLE.
- trigger  input  1  one-cycle pulse per accepted trigger; a multi-cycle high counts once per cycle.
- threshold  input  CNT_W  maximum allowed triggers per window; 0 disables the rate check.
- clear_error  input  1  synchronous one-cycle request: drop the error and restart the window.
- error_trig_rate  output  1  registered rate error, to the TTS reporter.
- window_done  output  1  one-cycle pulse on the cycle after each window closes.
- window_count  output  CNT_W  trigger total of the last completed window, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; window, trigger and recovery counters all 0.
  - error_trig_rate=0, window_done=0, window_count=0.
- States: IDLE, MONITOR, ERROR.
- IDLE:
  - Counters held at 0.
  - enable=1 -> MONITOR next cycle; the first window starts that cycle.
- enable=0 from any state:
  - -> IDLE next cycle; error_trig_rate drops next cycle.
  - window_count is retained; no window_done pulse is produced.
- Window counter (MONITOR/ERROR):
  - Runs 0..WINDOW_CYCLES-1 and wraps to 0.
  - The cycle at WINDOW_CYCLES-1 is "window end".
- Trigger counter:
  - Increments on trigger=1 and saturates at 2^CNT_W-1 (never wraps).
  - A trigger on the window-end cycle belongs to the closing window.
  - At window end, the closing total (including that cycle's trigger) is loaded into window_count and window_done=1 on the next cycle.
  - The trigger counter restarts at 0 for the new window.
- Over condition: threshold != 0 and closing total > threshold (strict compare). Total == threshold is not over.
- MONITOR, window end:
  - If over -> ERROR. error_trig_rate=1 one cycle after window end, same cycle as window_done.
  - Recovery counter cleared.
- ERROR, window end:
  - If over, recovery counter := 0.
  - Otherwise recovery counter +1; on reaching RECOVER_WINDOWS -> MONITOR and error_trig_rate=0 next cycle.
- Changing threshold mid-window: the value sampled at window end is used.
- clear_error=1 in MONITOR/ERROR:
  - -> MONITOR next cycle; error_trig_rate=0.
  - Window, trigger and recovery counters restart at 0.
  - window_count unchanged; no window_done pulse.
  - clear_error coincident with window end: clear wins; the closing window is discarded.
- clear_error in IDLE: no effect.
- enable=0 coincident with clear_error or window end: enable wins; go to IDLE.
- Reset asserted mid-window: immediate return to reset values, with no pulse.

Optional Feature:
- Macro TRIG_RATE_PEAK_EN.
- With it defined:
  - Adds output `peak_count` (CNT_W) holding the maximum window_count since reset or clear_error.
  - Updated with window_count on the cycle of window_done.
  - Reset value 0; enable=0 does not clear it.
- Without it: port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package (tts_pkg):
  - State encoding constants for IDLE/MONITOR/ERROR.
  - The TTS 4-bit code constants (Ready 1000, Overflow Warning 0001, Busy 0100, Sync Lost 0010, Error 1100), so the reporter and its feeders share them.
- One natural sub-module: `window_timer` — the free-running 0..WINDOW_CYCLES-1 counter with sync restart and a window-end strobe.
- Counting, compare and FSM stay in the top level.

Test Plan:
1. Reset then enable, WINDOW_CYCLES=100, threshold=5, 5 triggers per window -> window_done every 100 cycles, window_count=5, error_trig_rate stays 0.
2. 6 triggers in one window, the last on the window-end cycle -> window_count=6, error_trig_rate=1 on the same cycle as window_done.
3. RECOVER_WINDOWS=2, in ERROR: 3 triggers (quiet), 9 triggers (over), 2, 0 -> error drops only after the 4th window's window_done, not after the 1st.
4. trigger held high for 100 cycles, CNT_W=4 -> window_count saturates at 15; threshold=0 -> error stays 0.
5. clear_error on the window-end cycle while in ERROR -> error 0 next cycle, no window_done, window_count holds its previous value, next window_done 100 cycles later.
6. Assert reset mid-window with error=1 -> all outputs 0 immediately (asynchronous). With TRIG_RATE_PEAK_EN and windows of 3, 7, 4 triggers -> peak_count=7.
